// File: rtl/load_store_unit.sv
// MEM-stage load/store sequencer: one request at a time, alignment and range
// checks, one-cycle registered memory read latency, single-cycle response.
module load_store_unit #(
    parameter int MEM_BYTES = 4096
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic [4:0]  resp_rd,
    output logic        resp_exc,
    output logic [3:0]  resp_cause,
    output logic [31:0] resp_badaddr,
    output logic        stall,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_read_en,
    output logic        mem_write_en,
    output logic [3:0]  mem_byte_enable,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

    state_t      state;
    logic [2:0]  lat_funct3;
    logic        lat_write;
    logic [4:0]  lat_rd;

    logic        accept;
    logic        req_legal;
    logic        req_misaligned;
    logic        req_fault;
    logic        req_exc;
    logic [3:0]  req_cause;
    logic [3:0]  req_mask;

    // The memory already sign-extends the selected lane; only unsigned loads need zeroing.
    function automatic logic [31:0] load_fixup(input logic [2:0] f3, input logic [31:0] data);
        case (f3)
            3'b100:  return {24'b0, data[7:0]};
            3'b101:  return {16'b0, data[15:0]};
            default: return data;
        endcase
    endfunction

    assign req_ready = reset_n && (state == IDLE || state == RESP);
    assign stall     = reset_n && (state != IDLE);
    assign accept    = req_valid && req_ready;

    always_comb begin
        req_legal      = 1'b0;
        req_misaligned = 1'b0;
        req_mask       = 4'b1111;
        req_cause      = 4'd0;
        case (req_funct3)
            3'b000, 3'b001, 3'b010: req_legal = 1'b1;
            3'b100, 3'b101:         req_legal = !req_write;
            default:                req_legal = 1'b0;
        endcase
        case (req_funct3[1:0])
            2'b00: begin
                req_mask = 4'b0001 << req_addr[1:0];
            end
            2'b01: begin
                req_mask       = req_addr[1] ? 4'b1100 : 4'b0011;
                req_misaligned = req_addr[0];
            end
            default: begin
                req_mask       = 4'b1111;
                req_misaligned = (req_addr[1:0] != 2'b00);
            end
        endcase
        req_fault = (req_addr >= 32'(MEM_BYTES));
        if (!req_legal)
            req_cause = 4'd2;
        else if (req_misaligned)
            req_cause = req_write ? 4'd6 : 4'd4;
        else if (req_fault)
            req_cause = req_write ? 4'd7 : 4'd5;
        req_exc = !req_legal || req_misaligned || req_fault;
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            lat_funct3 <= req_funct3;
            lat_write  <= req_write;
            lat_rd     <= req_rd;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state           <= IDLE;
            resp_valid      <= 1'b0;
            resp_rdata      <= 32'd0;
            resp_rd         <= 5'd0;
            resp_exc        <= 1'b0;
            resp_cause      <= 4'd0;
            resp_badaddr    <= 32'd0;
            mem_addr        <= 32'd0;
            mem_wdata       <= 32'd0;
            mem_read_en     <= 1'b0;
            mem_write_en    <= 1'b0;
            mem_byte_enable <= 4'd0;
        end else begin
            resp_valid      <= 1'b0;
            mem_read_en     <= 1'b0;
            mem_write_en    <= 1'b0;
            mem_byte_enable <= 4'd0;
            case (state)
                ISSUE: begin
                    if (lat_write) begin
                        state        <= RESP;
                        resp_valid   <= 1'b1;
                        resp_rdata   <= 32'd0;
                        resp_rd      <= lat_rd;
                        resp_exc     <= 1'b0;
                        resp_cause   <= 4'd0;
                        resp_badaddr <= 32'd0;
                    end else begin
                        state <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    state        <= RESP;
                    resp_valid   <= 1'b1;
                    resp_rdata   <= load_fixup(lat_funct3, mem_rdata);
                    resp_rd      <= lat_rd;
                    resp_exc     <= 1'b0;
                    resp_cause   <= 4'd0;
                    resp_badaddr <= 32'd0;
                end
                default: begin
                    // IDLE and RESP both accept; RESP-cycle accept gives back-to-back throughput.
                    state <= IDLE;
                    if (accept) begin
                        mem_addr  <= req_addr;
                        mem_wdata <= req_wdata;
                        if (req_exc) begin
                            state        <= RESP;
                            resp_valid   <= 1'b1;
                            resp_rdata   <= 32'd0;
                            resp_rd      <= req_rd;
                            resp_exc     <= 1'b1;
                            resp_cause   <= req_cause;
                            resp_badaddr <= req_addr;
                        end else begin
                            state           <= ISSUE;
                            mem_read_en     <= !req_write;
                            mem_write_en    <= req_write;
                            mem_byte_enable <= req_mask;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: memory model, spec-level response model checked
// every cycle, and literal expectations for the directed vectors.
module tb_load_store_unit;

    logic        clk;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic [4:0]  resp_rd;
    logic        resp_exc;
    logic [3:0]  resp_cause;
    logic [31:0] resp_badaddr;
    logic        stall;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_read_en;
    logic        mem_write_en;
    logic [3:0]  mem_byte_enable;
    logic [31:0] mem_rdata;

    load_store_unit #(.MEM_BYTES(4096)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_rd(resp_rd),
        .resp_exc(resp_exc), .resp_cause(resp_cause), .resp_badaddr(resp_badaddr),
        .stall(stall), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
        .mem_byte_enable(mem_byte_enable), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // ---------------- word-organised data memory ----------------
    logic [31:0] mem_words [0:1023];

    function automatic int low_lane(input logic [3:0] m);
        for (int i = 0; i < 4; i++) if (m[i]) return i;
        return 0;
    endfunction

    function automatic logic [31:0] mem_extract(input logic [31:0] word, input logic [3:0] m);
        logic [31:0] v;
        v = word >> (8 * low_lane(m));
        case ($countones(m))
            1:       return {{24{v[7]}}, v[7:0]};
            2:       return {{16{v[15]}}, v[15:0]};
            default: return word;
        endcase
    endfunction

    initial begin
        for (int i = 0; i < 1024; i++) mem_words[i] = 32'd0;
        mem_rdata = 32'd0;
    end

    always @(posedge clk) begin
        if (mem_write_en) begin
            for (int i = 0; i < 4; i++)
                if (mem_byte_enable[i])
                    mem_words[mem_addr[11:2]][8*i +: 8] = mem_wdata[8*(i - low_lane(mem_byte_enable)) +: 8];
        end
        if (mem_read_en)
            mem_rdata <= mem_extract(mem_words[mem_addr[11:2]], mem_byte_enable);
    end

    // ---------------- spec-level model ----------------
    typedef struct {
        logic        w;
        logic [4:0]  rd;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        exc;
        logic [3:0]  cause;
        logic [3:0]  mask;
        int          due;
        int          issue;
    } item_t;

    item_t       q[$];
    logic [7:0]  shadow [0:4095];
    int          cyc = 0;
    bit          rst_pend = 0;
    bit          armed = 0;
    bit          acc_next = 0;
    logic [4:0]  last_acc_rd = 0;

    logic [31:0] lit_rdata [0:31];
    logic [31:0] lit_badaddr [0:31];
    logic [3:0]  lit_cause [0:31];
    logic [3:0]  lit_wmask [0:31];
    logic [31:0] lit_wdata [0:31];
    int          lit_cyc [0:31];
    int          acc_cyc [0:31];
    bit          lit_seen [0:31];
    bit          strobe_seen [0:31];

    initial begin
        for (int i = 0; i < 4096; i++) shadow[i] = 8'h00;
        for (int i = 0; i < 32; i++) begin
            lit_rdata[i] = 0; lit_badaddr[i] = 0; lit_cause[i] = 0; lit_wmask[i] = 0;
            lit_wdata[i] = 0; lit_cyc[i] = 0; acc_cyc[i] = 0; lit_seen[i] = 0; strobe_seen[i] = 0;
        end
    end

    function automatic item_t model_accept(input logic w, input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] d, input logic [4:0] rd, input int k);
        item_t it;
        int size;
        bit legal;
        logic [31:0] v;
        legal = w ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        it.w = w; it.rd = rd; it.addr = a; it.wdata = d; it.rdata = 0;
        it.exc = 1; it.cause = 0; it.mask = 0;
        if (!legal)                 it.cause = 2;
        else if ((a % size) != 0)   it.cause = w ? 6 : 4;
        else if (a >= 4096)         it.cause = w ? 7 : 5;
        else                        it.exc = 0;
        if (!it.exc) begin
            it.mask = 4'(((1 << size) - 1) << (a % 4));
            if (w) begin
                for (int b = 0; b < size; b++) shadow[a + b] = d[8*b +: 8];
            end else begin
                v = 0;
                for (int b = 0; b < size; b++) v = v | (32'(shadow[a + b]) << (8 * b));
                if (!f3[2] && size == 1) v = 32'($signed(v[7:0]));
                if (!f3[2] && size == 2) v = 32'($signed(v[15:0]));
                it.rdata = v;
            end
        end
        it.due   = k + (it.exc ? 1 : (w ? 2 : 3));
        it.issue = k + 1;
        return it;
    endfunction

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        bit ready_exp;
        bit stall_exp;
        bit resp_due;
        bit issue_now;
        cyc++;
        if (rst_pend) begin
            armed = 1;
            chk("rst_resp_valid", 32'(resp_valid), 0);
            chk("rst_resp_rdata", resp_rdata, 0);
            chk("rst_resp_rd", 32'(resp_rd), 0);
            chk("rst_resp_exc", 32'(resp_exc), 0);
            chk("rst_resp_cause", 32'(resp_cause), 0);
            chk("rst_resp_badaddr", resp_badaddr, 0);
            chk("rst_mem_addr", mem_addr, 0);
            chk("rst_mem_wdata", mem_wdata, 0);
            chk("rst_mem_strobes", {29'd0, mem_read_en, mem_write_en, 1'b0}, 0);
            chk("rst_mem_byte_enable", 32'(mem_byte_enable), 0);
        end
        ready_exp = reset_n && !(q.size() > 0 && q[0].due > cyc);
        stall_exp = reset_n && (q.size() > 0);
        resp_due  = (q.size() > 0) && (q[0].due == cyc);
        issue_now = (q.size() > 0) && !q[0].exc && (q[0].issue == cyc);
        if (armed) begin
            chk("req_ready", 32'(req_ready), 32'(ready_exp));
            chk("stall", 32'(stall), 32'(stall_exp));
            chk("resp_valid", 32'(resp_valid), 32'(resp_due));
            if (resp_due) begin
                chk("resp_rd", 32'(resp_rd), 32'(q[0].rd));
                chk("resp_exc", 32'(resp_exc), 32'(q[0].exc));
                chk("resp_rdata", resp_rdata, q[0].rdata);
                chk("resp_badaddr", resp_badaddr, q[0].exc ? q[0].addr : 32'd0);
                if (q[0].exc) chk("resp_cause", 32'(resp_cause), 32'(q[0].cause));
            end
            if (issue_now) begin
                chk("mem_write_en", 32'(mem_write_en), 32'(q[0].w));
                chk("mem_read_en", 32'(mem_read_en), 32'(!q[0].w));
                chk("mem_byte_enable", 32'(mem_byte_enable), 32'(q[0].mask));
                chk("mem_addr", mem_addr, q[0].addr);
                if (q[0].w) chk("mem_wdata", mem_wdata, q[0].wdata);
            end else begin
                chk("idle_strobes", {28'd0, mem_byte_enable}
                    | {30'd0, mem_read_en, mem_write_en}, 0);
            end
        end
        if (resp_valid) begin
            lit_seen[resp_rd]    = 1;
            lit_rdata[resp_rd]   = resp_rdata;
            lit_cause[resp_rd]   = resp_cause;
            lit_badaddr[resp_rd] = resp_badaddr;
            lit_cyc[resp_rd]     = cyc;
        end
        if (mem_read_en || mem_write_en) strobe_seen[last_acc_rd] = 1;
        if (mem_write_en) begin
            lit_wmask[last_acc_rd] = mem_byte_enable;
            lit_wdata[last_acc_rd] = mem_wdata;
        end
        if (resp_due) void'(q.pop_front());
        acc_next = 0;
        if (!reset_n) begin
            q.delete();
            rst_pend = 1;
        end else begin
            rst_pend = 0;
            if (req_valid && ready_exp) begin
                acc_next = 1;
                q.push_back(model_accept(req_write, req_funct3, req_addr, req_wdata, req_rd, cyc));
                acc_cyc[req_rd] = cyc;
                last_acc_rd = req_rd;
            end
        end
    end

    // ---------------- driver ----------------
    task automatic send(input logic w, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] d, input logic [4:0] rd, input bit hold);
        bit done;
        req_valid = 1; req_write = w; req_funct3 = f3; req_addr = a; req_wdata = d; req_rd = rd;
        done = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(posedge clk); #1;
            if (acc_next) done = 1;
        end
        if (!done) begin
            vectors++;
            miscompares++;
            $display("FAIL accept_timeout rd=%0d: got no accept, expected accept within 20 cycles", rd);
        end
        if (!hold) req_valid = 0;
    endtask

    task automatic idle(input int n);
        req_valid = 0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 0; req_valid = 0; req_write = 0; req_funct3 = 0;
        req_addr = 0; req_wdata = 0; req_rd = 0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1;
        idle(2);

        send(1, 3'b010, 32'h10, 32'h11223344, 5'd1, 0);  idle(3);
        send(0, 3'b010, 32'h10, 32'h0,        5'd2, 0);  idle(4);
        send(1, 3'b010, 32'h10, 32'h80FF7F01, 5'd3, 0);  idle(3);
        send(0, 3'b000, 32'h11, 32'h0,        5'd4, 0);  idle(4);
        send(0, 3'b000, 32'h12, 32'h0,        5'd5, 0);  idle(4);
        send(0, 3'b100, 32'h13, 32'h0,        5'd6, 0);  idle(4);
        send(0, 3'b101, 32'h12, 32'h0,        5'd7, 0);  idle(4);
        send(1, 3'b001, 32'h0E, 32'h1234ABCD, 5'd8, 0);  idle(3);
        send(0, 3'b010, 32'h0C, 32'h0,        5'd9, 0);  idle(4);
        send(0, 3'b010, 32'h06, 32'h0,        5'd10, 0); idle(2);
        send(1, 3'b010, 32'h1000, 32'hDEAD,   5'd11, 0); idle(2);
        send(0, 3'b001, 32'h12, 32'h0,        5'd12, 0); idle(4);
        send(1, 3'b000, 32'h05, 32'h55,       5'd13, 0); idle(3);
        send(0, 3'b010, 32'h04, 32'h0,        5'd14, 0); idle(4);
        send(0, 3'b001, 32'h11, 32'h0,        5'd15, 0); idle(2);
        send(1, 3'b001, 32'h01, 32'h0,        5'd16, 0); idle(2);
        send(0, 3'b010, 32'h2000, 32'h0,      5'd17, 0); idle(2);
        send(0, 3'b011, 32'h03, 32'h0,        5'd18, 0); idle(2);
        send(1, 3'b100, 32'h1001, 32'h0,      5'd19, 0); idle(2);
        send(0, 3'b010, 32'h1001, 32'h0,      5'd23, 0); idle(2);

        send(0, 3'b010, 32'h0, 32'h0, 5'd20, 1);
        send(0, 3'b010, 32'h4, 32'h0, 5'd21, 1);
        send(0, 3'b010, 32'h8, 32'h0, 5'd22, 0);
        idle(5);

        // reset while the load sits in CAPTURE
        send(0, 3'b010, 32'h10, 32'h0, 5'd25, 0);
        @(posedge clk); #1 reset_n = 0;
        @(posedge clk); #1 reset_n = 1;
        idle(5);
        send(0, 3'b010, 32'h10, 32'h0, 5'd26, 0);
        idle(6);

        chk("lit_sw_mask", 32'(lit_wmask[1]), 32'hF);
        chk("lit_sw_latency", 32'(lit_cyc[1] - acc_cyc[1]), 2);
        chk("lit_lw_rdata", lit_rdata[2], 32'h11223344);
        chk("lit_lw_latency", 32'(lit_cyc[2] - acc_cyc[2]), 3);
        chk("lit_lb_11", lit_rdata[4], 32'h0000007F);
        chk("lit_lb_12", lit_rdata[5], 32'hFFFFFFFF);
        chk("lit_lbu_13", lit_rdata[6], 32'h00000080);
        chk("lit_lhu_12", lit_rdata[7], 32'h000080FF);
        chk("lit_sh_mask", 32'(lit_wmask[8]), 32'hC);
        chk("lit_sh_wdata_lo", 32'(lit_wdata[8][15:0]), 32'hABCD);
        chk("lit_lw_0c", lit_rdata[9], 32'hABCD0000);
        chk("lit_lw6_cause", 32'(lit_cause[10]), 4);
        chk("lit_lw6_badaddr", lit_badaddr[10], 32'h6);
        chk("lit_lw6_latency", 32'(lit_cyc[10] - acc_cyc[10]), 1);
        chk("lit_lw6_no_strobe", 32'(strobe_seen[10]), 0);
        chk("lit_sw1000_cause", 32'(lit_cause[11]), 7);
        chk("lit_sw1000_no_strobe", 32'(strobe_seen[11]), 0);
        chk("lit_lh_12", lit_rdata[12], 32'hFFFF80FF);
        chk("lit_sb_then_lw", lit_rdata[14], 32'h00005500);
        chk("lit_lh_misaligned", 32'(lit_cause[15]), 4);
        chk("lit_sh_misaligned", 32'(lit_cause[16]), 6);
        chk("lit_lw_fault", 32'(lit_cause[17]), 5);
        chk("lit_illegal_load", 32'(lit_cause[18]), 2);
        chk("lit_illegal_store_prio", 32'(lit_cause[19]), 2);
        chk("lit_misaligned_prio", 32'(lit_cause[23]), 4);
        chk("lit_b2b_gap1", 32'(lit_cyc[21] - lit_cyc[20]), 3);
        chk("lit_b2b_gap2", 32'(lit_cyc[22] - lit_cyc[21]), 3);
        chk("lit_reset_no_resp", 32'(lit_seen[25]), 0);
        chk("lit_post_reset_lw", lit_rdata[26], 32'h80FF7F01);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Sits in the MEM stage between the pipeline and the 4 KB word-organised data memory, and sequences every load and store. It accepts one request at a time from EX/MEM over a valid/ready handshake, checks alignment and address range, and drives the memory's address/data/read/write/byte-enable ports. It absorbs the memory's one-cycle registered read latency, fixes up unsigned loads, and returns a single-cycle response with an optional exception to writeback.

## Interface
- MEM_BYTES, 4096: size of the data memory in bytes; addresses at or above this fault.
- clk  in  1  clock; all state updates on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request this cycle.
- req_write  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I width/sign code.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified.
- req_rd  in  5  destination register tag, echoed back.
- resp_valid  out  1  one-cycle response strobe.
- resp_rdata  out  32  load result; 0 for stores and exceptions.
- resp_rd  out  5  echoed tag.
- resp_exc  out  1  exception flag.
- resp_cause  out  4  2 illegal funct3, 4 load misaligned, 5 load fault, 6 store misaligned, 7 store fault.
- resp_badaddr  out  32  faulting address; 0 if no exception.
- stall  out  1  high whenever state != IDLE.
- mem_addr  out  32  memory address.
- mem_wdata  out  32  store data, unshifted.
- mem_read_en  out  1  memory read strobe.
- mem_write_en  out  1  memory write strobe.
- mem_byte_enable  out  4  byte-lane mask.
- mem_rdata  in  32  registered memory read data, lane-extracted and sign-extended.

## Operation
- FSM states: IDLE, ISSUE, CAPTURE, RESP.
- A request is accepted on a rising edge where req_valid and req_ready are both high. The unit latches addr, wdata, funct3, write and rd.
- req_ready is 1 in IDLE and RESP, otherwise 0. It is also 0 while reset_n is low.
- Legal loads: funct3 000, 001, 010, 100, 101. Legal stores: funct3 000, 001, 010. Anything else raises cause 2.
- Byte-enable generation:
  - Byte (x00): 0001 << addr[1:0].
  - Half (x01): addr[1] ? 1100 : 0011. Misaligned if addr[0] = 1.
  - Word (010): 1111. Misaligned if addr[1:0] != 0.
- Exception priority: illegal funct3, then misaligned, then access fault (addr >= MEM_BYTES).
- Exception path: accept goes directly to RESP. No memory strobe is issued.
- Store path: accept goes to ISSUE, then RESP.
  - ISSUE drives mem_write_en = 1 with the computed mask for exactly one cycle.
  - mem_wdata = latched wdata, unshifted; memory places the low bits in the selected lane.
- Load path: accept goes to ISSUE, then CAPTURE, then RESP.
  - ISSUE drives mem_read_en = 1 with the computed mask.
  - CAPTURE registers the result:
    - LB, LH, LW: mem_rdata passed through unchanged.
    - LBU: {24'b0, mem_rdata[7:0]}.
    - LHU: {16'b0, mem_rdata[15:0]}.
- RESP asserts resp_valid for one cycle. Next state is ISSUE or RESP if a new request is accepted that edge, otherwise IDLE.
- Outside ISSUE: mem_read_en, mem_write_en and mem_byte_enable are 0. mem_addr and mem_wdata hold their latched values.
- All outputs are registered, except req_ready and stall, which are decoded from state.

## Timing
- Reset values: state IDLE; every registered output is 0. req_ready and stall are 0 while reset_n is low, then 1 and 0 respectively in the first cycle after release.
- Reset asserted mid-operation: state forced to IDLE at that edge; no resp_valid is produced.
  - A write strobe already high in ISSUE still commits at that edge, because the memory ignores reset for writes.
- Latency from accepting edge to resp_valid high: exception 1 cycle, store 2 cycles, load 3 cycles.
- Throughput: stores one per 2 cycles, loads one per 3 cycles, via RESP-cycle accept.
- resp_rdata, resp_rd, resp_exc, resp_cause and resp_badaddr are valid only while resp_valid is high. They hold their values afterwards.

## Test plan
- SW 0x11223344 to 0x10, then LW 0x10: mem_write_en pulses in cycle 1 with mask 1111; the load's resp_valid comes 3 cycles after accept with resp_rdata 0x11223344.
- Memory word 0x10 = 0x80FF7F01:
  - LB 0x11 returns 0x0000007F.
  - LB 0x12 returns 0xFFFFFFFF.
  - LBU 0x13 returns 0x00000080.
  - LHU 0x12 returns 0x000080FF.
- SH 0xABCD to 0x0E: mask 1100, mem_wdata[15:0] = 0xABCD. A subsequent LW of 0x0C returns 0xABCD in bits 31:16.
- LW at 0x0000_0006: resp_valid 1 cycle after accept with exc = 1, cause 4, badaddr 0x6, and no mem_read_en. SW at 0x1000 with MEM_BYTES = 4096: cause 7, and no mem_write_en.
- Loads at 0x0, 0x4, 0x8 with req_valid held high: each is accepted in the RESP cycle of the previous load, giving resp_valid every 3 cycles with in-order resp_rd tags.
- reset_n low during CAPTURE of a load: no resp_valid follows; all outputs are 0 after the edge; req_ready is 1 in the cycle after release.
